// File: rtl/prim_ram_1p_adapter.sv
// Valid/ready front-end for a single-port synchronous SRAM: forwards requests,
// captures read data one cycle later into a credit-protected response FIFO.
module prim_ram_1p_adapter #(
  parameter  int Width    = 32,
  parameter  int Depth    = 128,
  parameter  int RspDepth = 2,
  localparam int Aw       = $clog2(Depth),
  localparam int Bw       = Width / 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_write_i,
  input  logic [Aw-1:0]    req_addr_i,
  input  logic [Width-1:0] req_wdata_i,
  input  logic [Bw-1:0]    req_be_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [Width-1:0] rsp_rdata_o,
  output logic             rsp_write_o,
  output logic             rsp_err_o,
  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [Aw-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  output logic [Width-1:0] ram_wmask_o,
  input  logic [Width-1:0] ram_rdata_i
);

  localparam int Cw = $clog2(RspDepth + 1);
  localparam int Pw = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam logic [Aw:0]   DepthW    = (Aw + 1)'(Depth);
  localparam logic [Cw:0]   RspDepthW = (Cw + 1)'(RspDepth);
  localparam logic [Pw-1:0] LastPtr   = Pw'(RspDepth - 1);

  logic             w_acc;
  logic             w_oob;
  logic             w_pop;
  logic             w_push;
  logic [Cw:0]      w_occ;
  logic [Width-1:0] w_push_rdata;

  logic             r_inflight;
  logic             r_if_write;
  logic             r_if_err;
  logic [Pw-1:0]    r_wptr;
  logic [Pw-1:0]    r_rptr;
  logic [Cw-1:0]    r_count;
  logic [Width-1:0] r_fifo_rdata [RspDepth];
  logic             r_fifo_write [RspDepth];
  logic             r_fifo_err   [RspDepth];

  function automatic logic [Pw-1:0] ptr_inc(input logic [Pw-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // Request side: acceptance, range check and SRAM pin drive
  assign w_oob       = ({1'b0, req_addr_i} >= DepthW);
  assign w_acc       = req_valid_i && req_ready_o;
  assign ram_req_o   = w_acc && !w_oob;
  assign ram_write_o = req_write_i;
  assign ram_addr_o  = req_addr_i;
  assign ram_wdata_o = req_wdata_i;

  always_comb begin
    ram_wmask_o = '0;
    for (int b = 0; b < Bw; b++) begin
      ram_wmask_o[8*b +: 8] = {8{req_be_i[b] & req_write_i}};
    end
  end

  // A slot is reserved for every request still in flight, so a response
  // can never arrive to a full FIFO; a same-cycle pop frees its slot at once.
  assign w_pop       = rsp_valid_o && rsp_ready_i;
  assign w_occ       = {1'b0, r_count} + {{Cw{1'b0}}, r_inflight} - {{Cw{1'b0}}, w_pop};
  assign req_ready_o = (w_occ < RspDepthW);

  // In-flight stage: one cycle of SRAM read latency
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_acc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_acc) begin
      r_if_write <= req_write_i;
      r_if_err   <= w_oob;
    end
  end

  assign w_push       = r_inflight;
  assign w_push_rdata = (!r_if_write && !r_if_err) ? ram_rdata_i : '0;

  // Response FIFO storage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < RspDepth; i++) begin
        r_fifo_rdata[i] <= '0;
        r_fifo_write[i] <= 1'b0;
        r_fifo_err[i]   <= 1'b0;
      end
    end else if (w_push) begin
      r_fifo_rdata[r_wptr] <= w_push_rdata;
      r_fifo_write[r_wptr] <= r_if_write;
      r_fifo_err[r_wptr]   <= r_if_err;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rsp_valid_o = (r_count != '0);
  assign rsp_rdata_o = r_fifo_rdata[r_rptr];
  assign rsp_write_o = r_fifo_write[r_rptr];
  assign rsp_err_o   = r_fifo_err[r_rptr];

endmodule

// File: tb/tb_prim_ram_1p_adapter.sv
// Directed bench for prim_ram_1p_adapter (Depth=100, RspDepth=2) with a
// behavioural SRAM and an in-order expected-response queue.
module tb_prim_ram_1p_adapter;
  localparam int W  = 32;
  localparam int D  = 100;
  localparam int RD = 2;
  localparam int AW = 7;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          req_valid_i, req_ready_o, req_write_i;
  logic [AW-1:0] req_addr_i;
  logic [W-1:0]  req_wdata_i;
  logic [BW-1:0] req_be_i;
  logic          rsp_valid_o, rsp_ready_i, rsp_write_o, rsp_err_o;
  logic [W-1:0]  rsp_rdata_o;
  logic          ram_req_o, ram_write_o;
  logic [AW-1:0] ram_addr_o;
  logic [W-1:0]  ram_wdata_o, ram_wmask_o, ram_rdata_i;

  always #5 clk = ~clk;

  prim_ram_1p_adapter #(.Width(W), .Depth(D), .RspDepth(RD)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_write_o(rsp_write_o), .rsp_err_o(rsp_err_o),
    .ram_req_o(ram_req_o), .ram_write_o(ram_write_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_wmask_o(ram_wmask_o), .ram_rdata_i(ram_rdata_i)
  );

  // Behavioural SRAM; 128 words so a wrongly issued out-of-range access is visible.
  logic [W-1:0] sram [128];
  always @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < 128; i++) sram[i] <= {4{8'(i)}};
    end else if (ram_req_o) begin
      if (ram_write_o) sram[ram_addr_o] <= (sram[ram_addr_o] & ~ram_wmask_o) | (ram_wdata_o & ram_wmask_o);
      else             ram_rdata_i      <= sram[ram_addr_o];
    end
  end

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
    logic [BW-1:0] be;
    logic [W-1:0]  exp_mask;
    logic          exp_req;
    logic          exp_err;
    logic [W-1:0]  exp_rdata;
  } vec_t;

  typedef struct {
    logic         wr;
    logic         err;
    logic [W-1:0] rdata;
    int           acc_cyc;
  } exp_t;

  vec_t         tbl [12];
  exp_t         expq [$];
  exp_t         tbl_exp;
  logic [W-1:0] ref_mem [128];
  int           n_vec = 0, n_err = 0, cyc = 0, n_acc = 0, n_pop = 0, base;
  bit           chk_lat, use_tbl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] be2mask(input logic [BW-1:0] be);
    logic [W-1:0] m;
    for (int b = 0; b < BW; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

  task automatic drive(input logic v, input logic wr, input logic [AW-1:0] a,
                       input logic [W-1:0] d, input logic [BW-1:0] be, input logic rr);
    req_valid_i = v; req_write_i = wr; req_addr_i = a;
    req_wdata_i = d; req_be_i = be; rsp_ready_i = rr;
    #1;
  endtask

  // Scoreboard one cycle: check a popped response, record an accepted request,
  // then advance to the next falling edge.
  task automatic tick();
    exp_t e, h;
    if (rsp_valid_o && rsp_ready_i) begin
      n_pop++;
      if (expq.size() == 0) chk("rsp_unexpected", 32'(rsp_valid_o), 32'd0);
      else begin
        h = expq.pop_front();
        chk("rsp_write", 32'(rsp_write_o), 32'(h.wr));
        chk("rsp_err", 32'(rsp_err_o), 32'(h.err));
        chk("rsp_rdata", rsp_rdata_o, h.rdata);
        if (chk_lat) chk("rsp_latency", 32'(cyc - h.acc_cyc), 32'd2);
      end
    end
    if (req_valid_i && req_ready_o) begin
      n_acc++;
      if (use_tbl) e = tbl_exp;
      else begin
        e.wr    = req_write_i;
        e.err   = (int'(req_addr_i) >= D);
        e.rdata = (!e.wr && !e.err) ? ref_mem[req_addr_i] : '0;
      end
      e.acc_cyc = cyc;
      if (req_write_i && int'(req_addr_i) < D)
        ref_mem[req_addr_i] = (ref_mem[req_addr_i] & ~be2mask(req_be_i)) | (req_wdata_i & be2mask(req_be_i));
      expq.push_back(e);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
    for (int k = 0; k < 20 && expq.size() > 0; k++) begin
      tick();
      #1;
    end
    chk("drain_left", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic          v, wr, rr;
    logic [AW-1:0] a;
    int            r;

    tbl[0]  = '{1'b1, 7'd5,   32'hDEADBEEF, 4'b0101, 32'h00FF00FF, 1'b1, 1'b0, 32'h00000000};
    tbl[1]  = '{1'b0, 7'd5,   32'h00000000, 4'b1111, 32'h00000000, 1'b1, 1'b0, 32'h05AD05EF};
    tbl[2]  = '{1'b0, 7'd0,   32'h00000000, 4'b0000, 32'h00000000, 1'b1, 1'b0, 32'h00000000};
    tbl[3]  = '{1'b1, 7'd10,  32'hCAFEF00D, 4'b1111, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000000};
    tbl[4]  = '{1'b0, 7'd10,  32'h00000000, 4'b0000, 32'h00000000, 1'b1, 1'b0, 32'hCAFEF00D};
    tbl[5]  = '{1'b0, 7'd99,  32'h00000000, 4'b0000, 32'h00000000, 1'b1, 1'b0, 32'h63636363};
    tbl[6]  = '{1'b0, 7'd100, 32'h00000000, 4'b0000, 32'h00000000, 1'b0, 1'b1, 32'h00000000};
    tbl[7]  = '{1'b1, 7'd127, 32'h12345678, 4'b1111, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h00000000};
    tbl[8]  = '{1'b1, 7'd3,   32'h00000000, 4'b1000, 32'hFF000000, 1'b1, 1'b0, 32'h00000000};
    tbl[9]  = '{1'b0, 7'd3,   32'h00000000, 4'b0000, 32'h00000000, 1'b1, 1'b0, 32'h00030303};
    tbl[10] = '{1'b0, 7'd11,  32'h00000000, 4'b0000, 32'h00000000, 1'b1, 1'b0, 32'h0B0B0B0B};
    tbl[11] = '{1'b0, 7'd120, 32'h00000000, 4'b0000, 32'h00000000, 1'b0, 1'b1, 32'h00000000};
    for (int i = 0; i < 128; i++) ref_mem[i] = {4{8'(i)}};

    rst_i = 1'b1;
    chk_lat = 1'b0; use_tbl = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready_o), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("reset_rsp_write", 32'(rsp_write_o), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err_o), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata_o, 32'd0);
    chk("reset_ram_req", 32'(ram_req_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk);

    // Table vectors, back to back with the response side always ready
    use_tbl = 1'b1; chk_lat = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tbl_exp = '{tbl[i].wr, tbl[i].exp_err, tbl[i].exp_rdata, 0};
      drive(1'b1, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, 1'b1);
      chk("tbl_req_ready", 32'(req_ready_o), 32'd1);
      chk("tbl_ram_req", 32'(ram_req_o), 32'(tbl[i].exp_req));
      chk("tbl_ram_wmask", ram_wmask_o, tbl[i].exp_mask);
      chk("tbl_ram_addr", 32'(ram_addr_o), 32'(tbl[i].addr));
      chk("tbl_ram_wdata", ram_wdata_o, tbl[i].wdata);
      tick();
    end
    use_tbl = 1'b0;
    drain();
    chk("oob_sram_untouched", sram[127], 32'h7F7F7F7F);

    // Streaming reads 0..15
    base = n_acc;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, AW'(i), '0, '0, 1'b1);
      chk("stream_req_ready", 32'(req_ready_o), 32'd1);
      tick();
    end
    drain();
    chk("stream_accepts", 32'(n_acc - base), 32'd16);

    // Back-pressure
    chk_lat = 1'b0;
    base = n_acc;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, AW'(30 + k), '0, '0, 1'b0);
      tick();
    end
    chk("bp_accepts", 32'(n_acc - base), 32'd2);
    drive(1'b1, 1'b0, 7'd35, '0, '0, 1'b0);
    chk("bp_ready_low", 32'(req_ready_o), 32'd0);
    tick();
    drive(1'b1, 1'b0, 7'd36, '0, '0, 1'b1);
    chk("bp_ready_on_pop", 32'(req_ready_o), 32'd1);
    tick();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
    chk("bp_ready_refull", 32'(req_ready_o), 32'd0);
    tick();
    drain();
    chk("bp_accepts_total", 32'(n_acc - base), 32'd3);

    // Random stalls to exercise pointer wrap and simultaneous push/pop
    for (int k = 0; k < 60; k++) begin
      v  = ($urandom_range(0, 3) != 0);
      r  = $urandom_range(0, 9);
      a  = (r < 7) ? AW'(20 + r) : AW'(96 + r);
      wr = $urandom_range(0, 1) == 1;
      rr = ($urandom_range(0, 2) != 0);
      drive(v, wr, a, $urandom, BW'($urandom), rr);
      tick();
    end
    drain();
    chk("one_rsp_per_req", 32'(n_pop), 32'(n_acc));

    // Asynchronous reset mid-cycle discards queued responses
    drive(1'b1, 1'b0, 7'd1, '0, '0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 7'd2, '0, '0, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
    tick();
    chk("pre_reset_valid", 32'(rsp_valid_o), 32'd1);
    chk("pre_reset_ready", 32'(req_ready_o), 32'd0);
    #3;
    rst_i = 1'b1;
    #1;
    chk("async_reset_valid", 32'(rsp_valid_o), 32'd0);
    chk("async_reset_ready", 32'(req_ready_o), 32'd1);
    expq.delete();
    @(negedge clk);
    rst_i = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("post_reset_valid", 32'(rsp_valid_o), 32'd0);
      tick();
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/prim_ram_1p_adapter.md
# prim_ram_1p_adapter

Request/response front-end for the synchronous single-port SRAM primitive (`prim_ram_1p`). It accepts a valid/ready request stream with byte enables and drives the SRAM's `req`/`write`/`addr`/`wdata`/`wmask` pins. It captures the read data the SRAM returns one cycle later into a small response FIFO with valid/ready back-pressure. Credit tracking ensures a request is never issued to the SRAM unless its response has guaranteed space, so no SRAM read data is ever dropped.

## Interface
- `Width`, default 32: data width in bits; must be a multiple of 8.
- `Depth`, default 128: number of SRAM words; need not be a power of two.
- `RspDepth`, default 2: number of response FIFO entries; must be ≥ 1. A value of 2 or more gives full throughput.
- Derived: `Aw = $clog2(Depth)`, `Bw = Width/8`.

Ports:
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request accepted this cycle when `req_valid_i && req_ready_o`.
- `req_write_i`  in  1  1 = write, 0 = read.
- `req_addr_i`  in  Aw  word address.
- `req_wdata_i`  in  Width  write data.
- `req_be_i`  in  Bw  byte enables (writes only).
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response consumed when `rsp_valid_o && rsp_ready_i`.
- `rsp_rdata_o`  out  Width  read data; 0 for writes and errors.
- `rsp_write_o`  out  1  echoes `req_write_i` of the matching request.
- `rsp_err_o`  out  1  1 when the request address was ≥ `Depth`.
- `ram_req_o`  out  1  to SRAM `req_i`.
- `ram_write_o`  out  1  to SRAM `write_i`.
- `ram_addr_o`  out  Aw  to SRAM `addr_i`.
- `ram_wdata_o`  out  Width  to SRAM `wdata_i`.
- `ram_wmask_o`  out  Width  to SRAM `wmask_i`; full bit mask.
- `ram_rdata_i`  in  Width  from SRAM `rdata_o`; valid one cycle after a read `ram_req_o`.

## Operation
- **Request acceptance:** `acc = req_valid_i && req_ready_o`.
- **Address range:** `oob = (req_addr_i >= Depth)`.
- **SRAM request:** `ram_req_o = acc && !oob`.
- **SRAM pass-through (combinational):** `ram_write_o = req_write_i`, `ram_addr_o = req_addr_i`, `ram_wdata_o = req_wdata_i`.
- **Write mask:** `ram_wmask_o[8*b +: 8] = {8{req_be_i[b]}}` when `req_write_i`; all zeros on reads.
- **In-flight stage:** registers `inflight`, `if_write`, `if_err`, loaded on every accepted request (including out-of-range ones). `inflight` clears the following cycle unless another request is accepted.
- **Response push:** when `inflight` = 1, push one entry `{write = if_write, err = if_err, rdata}` into the FIFO at the end of that cycle.
  - `rdata = ram_rdata_i` only if `!if_write && !if_err`; otherwise 0.
- **Response FIFO:**
  - Circular buffer of `RspDepth` entries with read/write pointers that wrap at `RspDepth`, plus an occupancy count of `$clog2(RspDepth+1)` bits.
  - The FIFO head drives `rsp_*_o`; `rsp_valid_o = (count != 0)`.
  - `pop = rsp_valid_o && rsp_ready_i`.
- **Credits:** `req_ready_o = (count + inflight - pop) < RspDepth`.
  - This is a combinational path from `rsp_ready_i` to `req_ready_o`, and is intended.
- **Simultaneous push and pop:** count is unchanged and both pointers advance. Pop while empty cannot occur; push while full cannot occur because credits prevent it.
- **Ordering:** responses return strictly in request order, one per accepted request.
- **Reset:** asynchronous. It clears `inflight`, both pointers and the count. Any in-flight or queued responses are discarded without being delivered.

## Timing
- **Reset values:**
  - `req_ready_o` = 1 (credits free).
  - `rsp_valid_o`, `rsp_write_o`, `rsp_err_o` = 0; `rsp_rdata_o` = 0, because FIFO storage resets to 0.
  - `ram_req_o` = 0 while `req_valid_i` = 0.
- **Latency:** a request accepted in cycle N is pushed at the end of N+1 and gives `rsp_valid_o` = 1 in N+2, if the FIFO was empty.
- **Throughput:** one request per cycle sustained when `RspDepth` ≥ 2 and `rsp_ready_i` is held high. With `RspDepth` = 1, throughput is at most one request per 2 cycles.
- **Back-pressure:** with `rsp_ready_i` held low, exactly `RspDepth` requests are accepted, then `req_ready_o` = 0 until a pop occurs. `req_ready_o` rises in the same cycle as that pop.
- **SRAM read data:** `ram_rdata_i` is sampled only in the cycle after a read request. SRAM read data is never needed later, because the SRAM holds `rdata` only until its next read.

## Test plan
- **Reset state:** assert `rst_i` mid-cycle, asynchronously → `rsp_valid_o` = 0 and `req_ready_o` = 1 immediately. Previously queued responses are never delivered after reset is released.
- **Write then read:** with `rsp_ready_i` = 1:
  - Write addr 5, data 0xDEADBEEF, be 4'b0101 → `ram_wmask_o` = 0x00FF00FF.
  - Then read addr 5 → responses arrive in cycles N+2 and N+3: `{write=1, rdata=0}`, then `{write=0, rdata=prior & 0xFF00FF00 | 0x00AD00EF}`.
- **Streaming:** 16 back-to-back reads of addrs 0–15 with `rsp_ready_i` = 1 → `req_ready_o` stays 1 throughout, and 16 consecutive in-order responses start 2 cycles after the first accept.
- **Back-pressure:** `rsp_ready_i` = 0 with `RspDepth` = 2 and continuous requests → exactly 2 accepted, then `req_ready_o` = 0. Raising `rsp_ready_i` for 1 cycle → `req_ready_o` = 1 in that same cycle, and no data is lost.
- **Out of range:** `Depth` = 100, read addr 100 → `ram_req_o` = 0, response `{err=1, rdata=0}` arrives 2 cycles later, and the SRAM contents are untouched.
- **Pointer wrap:** random stall pattern on `rsp_ready_i` across more than 3×`RspDepth` requests → every response matches a reference-model queue, confirming pointer wrap-around and simultaneous push/pop.
